// File: rtl/alu_mdu_ctrl.sv
// ALU-control decoder with an optional iterative RV32M multiply/divide unit.
// The decoder is purely combinational; the M unit stalls the pipeline while it iterates.
module alu_mdu_ctrl #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic            in_valid,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [3:0]      alu_sel,
    output logic            in_ready,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd15;

    localparam int             CW      = $clog2(XLEN);
    localparam logic [CW-1:0]  LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t              state, state_next;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     opb_r;
    logic [2:0]          f3_r;
    logic                neg_q_r, neg_r_r;
    logic [CW-1:0]       cnt_r;

    logic                is_m, accept, special, last_step;
    logic                rs1_signed, rs2_signed, rs1_neg, rs2_neg, div_zero, div_ovf;
    logic [XLEN-1:0]     rs1_mag, rs2_mag, special_res;
    logic [XLEN:0]       mul_sum, div_shift;
    logic [XLEN-1:0]     div_sub;
    logic                div_ok;
    logic [2*XLEN-1:0]   mul_next, div_next, mul_prod;
    logic [XLEN-1:0]     mul_res, div_res, quo, rem;

    always_comb begin
        alu_sel = ALU_PASS;
        case (alu_op)
            2'b00: alu_sel = ALU_ADD;
            2'b01: alu_sel = ALU_SUB;
            2'b10, 2'b11: begin
                case (funct3)
                    3'b000:  alu_sel = (alu_op == 2'b10 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_sel = ALU_SLL;
                    3'b010:  alu_sel = ALU_SLT;
                    3'b011:  alu_sel = ALU_SLTU;
                    3'b100:  alu_sel = ALU_XOR;
                    3'b101:  alu_sel = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_sel = ALU_OR;
                    3'b111:  alu_sel = ALU_AND;
                    default: alu_sel = ALU_PASS;
                endcase
            end
            default: alu_sel = ALU_PASS;
        endcase
    end

    // Operand preparation and the divide special cases resolved at accept
    always_comb begin
        is_m   = ENABLE_M && in_valid && (alu_op == 2'b10) && funct7_0;
        accept = is_m && (state == ST_IDLE);
        if (funct3[2]) begin
            rs1_signed = ~funct3[0];
            rs2_signed = ~funct3[0];
        end else begin
            rs1_signed = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
            rs2_signed = (funct3[1:0] == 2'b01);
        end
        rs1_neg     = rs1_signed && rs1[XLEN-1];
        rs2_neg     = rs2_signed && rs2[XLEN-1];
        rs1_mag     = rs1_neg ? -rs1 : rs1;
        rs2_mag     = rs2_neg ? -rs2 : rs2;
        div_zero    = (rs2 == '0);
        div_ovf     = rs1_signed && (rs1 == MIN_NEG) && (rs2 == '1);
        special     = funct3[2] && (div_zero || div_ovf);
        special_res = funct3[1] ? (div_zero ? rs1 : '0) : (div_zero ? '1 : rs1);
    end

    // One shift-add or restoring-divide step on the shared accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : '0);
        mul_next  = {mul_sum, acc_r[XLEN-1:1]};
        div_shift = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_ok    = (div_shift >= {1'b0, opb_r});
        div_sub   = div_shift[XLEN-1:0] - opb_r;
        div_next  = div_ok ? {div_sub, acc_r[XLEN-2:0], 1'b1}
                           : {div_shift[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        mul_prod  = neg_q_r ? -mul_next : mul_next;
        mul_res   = (f3_r[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
        quo       = div_next[XLEN-1:0];
        rem       = div_next[2*XLEN-1:XLEN];
        div_res   = f3_r[1] ? (neg_r_r ? -rem : rem) : (neg_q_r ? -quo : quo);
        last_step = (cnt_r == LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (special)        state_next = ST_DONE;
                    else if (funct3[2]) state_next = ST_DIV;
                    else                state_next = ST_MUL;
                end
            end
            ST_MUL:  if (last_step) state_next = ST_DONE;
            ST_DIV:  if (last_step) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        stall     = ((state == ST_IDLE) && is_m) || (state == ST_MUL) || (state == ST_DIV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc_r      <= '0;
            opb_r      <= '0;
            f3_r       <= '0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            cnt_r      <= '0;
            out_result <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        f3_r    <= funct3;
                        cnt_r   <= '0;
                        neg_q_r <= rs1_neg ^ rs2_neg;
                        neg_r_r <= rs1_neg;
                        // Divide keeps the dividend in the low half; multiply keeps the multiplier there
                        if (funct3[2]) begin
                            acc_r <= {{XLEN{1'b0}}, rs1_mag};
                            opb_r <= rs2_mag;
                        end else begin
                            acc_r <= {{XLEN{1'b0}}, rs2_mag};
                            opb_r <= rs1_mag;
                        end
                        if (special) out_result <= special_res;
                    end
                end
                ST_MUL: begin
                    acc_r <= mul_next;
                    cnt_r <= cnt_r + 1'b1;
                    if (last_step) out_result <= mul_res;
                end
                ST_DIV: begin
                    acc_r <= div_next;
                    cnt_r <= cnt_r + 1'b1;
                    if (last_step) out_result <= div_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Testbench for alu_mdu_ctrl: decode vector table, M-op vector table with a result scoreboard,
// reset abort sequence, and a second instance with the M unit disabled.
module tb_alu_mdu_ctrl;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7_5, funct7_0, in_valid;
    logic [XLEN-1:0] rs1, rs2;
    logic [3:0]      alu_sel, alu_sel_nom;
    logic            in_ready, stall, out_valid;
    logic            in_ready_nom, stall_nom, out_valid_nom;
    logic [XLEN-1:0] out_result, out_result_nom;

    int checks = 0;
    int errors = 0;
    bit nom_stall_seen = 1'b0;
    logic [XLEN-1:0] exp_q[$];

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic       f75;
        logic [3:0] sel;
    } dec_vec_t;

    typedef struct {
        logic [2:0]      f3;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        bit              special;
    } m_vec_t;

    dec_vec_t dec_tab[12];
    m_vec_t   m_tab[13];

    alu_mdu_ctrl #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
        .funct7_0(funct7_0), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .alu_sel(alu_sel),
        .in_ready(in_ready), .stall(stall), .out_valid(out_valid), .out_result(out_result)
    );

    alu_mdu_ctrl #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .rst(rst), .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
        .funct7_0(funct7_0), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .alu_sel(alu_sel_nom),
        .in_ready(in_ready_nom), .stall(stall_nom), .out_valid(out_valid_nom),
        .out_result(out_result_nom)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (stall_nom) nom_stall_seen = 1'b1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                                 input logic f70, input logic vld,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        alu_op   = op;
        funct3   = f3;
        funct7_5 = f75;
        funct7_0 = f70;
        in_valid = vld;
        rs1      = a;
        rs2      = b;
    endtask

    // Issue one M op and watch it for a bounded number of cycles
    task automatic runMOp(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] res, input bit special);
        int exp_cycle;
        int seen_cycle;
        bit stall_bad;
        logic [XLEN-1:0] got;
        exp_cycle  = special ? 1 : XLEN + 1;
        seen_cycle = -1;
        stall_bad  = 1'b0;
        @(negedge clk);
        applyStimulus(2'b10, f3, 1'b0, 1'b1, 1'b1, a, b);
        exp_q.push_back(res);
        #1;
        if (stall !== 1'b1) stall_bad = 1'b1;
        for (int c = 1; c <= XLEN + 4; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (stall !== (!special && c <= XLEN)) stall_bad = 1'b1;
            if (out_valid === 1'b1) begin
                seen_cycle = (seen_cycle == -1) ? c : -2;
                got = out_result;
                checkOutput({name, "_in_ready_done"}, in_ready, 0);
                if (exp_q.size() > 0) checkOutput({name, "_result"}, got, exp_q.pop_front());
                else checkOutput({name, "_sb_underflow"}, 1, 0);
            end
        end
        checkOutput({name, "_stall_window"}, stall_bad, 0);
        checkOutput({name, "_valid_cycle"}, seen_cycle, exp_cycle);
        checkOutput({name, "_sb_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bit abort_valid;

        dec_tab[0]  = '{2'b10, 3'b000, 1'b1, ALU_SUB};
        dec_tab[1]  = '{2'b11, 3'b000, 1'b1, ALU_ADD};
        dec_tab[2]  = '{2'b11, 3'b101, 1'b1, ALU_SRA};
        dec_tab[3]  = '{2'b10, 3'b001, 1'b0, ALU_SLL};
        dec_tab[4]  = '{2'b00, 3'b110, 1'b1, ALU_ADD};
        dec_tab[5]  = '{2'b01, 3'b000, 1'b0, ALU_SUB};
        dec_tab[6]  = '{2'b10, 3'b101, 1'b0, ALU_SRL};
        dec_tab[7]  = '{2'b10, 3'b111, 1'b0, ALU_AND};
        dec_tab[8]  = '{2'b11, 3'b010, 1'b0, ALU_SLT};
        dec_tab[9]  = '{2'b10, 3'b011, 1'b0, ALU_SLTU};
        dec_tab[10] = '{2'b11, 3'b110, 1'b1, ALU_OR};
        dec_tab[11] = '{2'b10, 3'b100, 1'b0, ALU_XOR};

        m_tab[0]  = '{3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        m_tab[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
        m_tab[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        m_tab[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 1'b0};
        m_tab[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0};
        m_tab[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0};
        m_tab[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,        1'b0};
        m_tab[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,         1'b0};
        m_tab[8]  = '{3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1};
        m_tab[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,         1'b1};
        m_tab[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        m_tab[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1};
        m_tab[12] = '{3'b111, 32'd9,        32'd0,        32'd9,         1'b1};

        rst = 1'b1;
        applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_result", out_result, 0);
        checkOutput("reset_stall", stall, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        rst = 1'b0;

        $display("[TB] decode sweep");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(dec_tab[i].op, dec_tab[i].f3, dec_tab[i].f75, 1'b0, 1'b1,
                          32'h1234_5678, 32'h0000_0003);
            #1;
            checkOutput($sformatf("dec%0d_sel", i), alu_sel, dec_tab[i].sel);
            checkOutput($sformatf("dec%0d_stall", i), stall, 0);
            @(negedge clk);
            checkOutput($sformatf("dec%0d_idle", i), in_ready, 1);
        end

        $display("[TB] M operations");
        for (int i = 0; i < 13; i++) begin
            runMOp($sformatf("m%0d", i), m_tab[i].f3, m_tab[i].a, m_tab[i].b, m_tab[i].res,
                   m_tab[i].special);
        end

        $display("[TB] reset abort");
        @(negedge clk);
        applyStimulus(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd5, 32'd6);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_out_valid", out_valid, 0);
        abort_valid = 1'b0;
        for (int c = 0; c < XLEN + 4; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) abort_valid = 1'b1;
        end
        checkOutput("abort_no_valid", abort_valid, 0);
        runMOp("post_abort_mul", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0);

        $display("[TB] M disabled instance");
        @(negedge clk);
        applyStimulus(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd3, 32'd4);
        #1;
        checkOutput("nom_sel", alu_sel_nom, ALU_ADD);
        checkOutput("nom_stall_now", stall_nom, 0);
        @(negedge clk);
        checkOutput("nom_in_ready", in_ready_nom, 1);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("nom_stall_ever", nom_stall_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
